// File: rtl/bullet_pool.sv
// Player bullet pool: advances live bullets once per frame, spawns at the ship on fire,
// and renders the bullet colour for the current scan position with one clock of latency.
module bullet_pool #(
    parameter int unsigned N_BULLETS   = 8,
    parameter int unsigned BULLET_W    = 2,
    parameter int unsigned BULLET_H    = 6,
    parameter int unsigned SPEED       = 4,
    parameter int unsigned COOLDOWN    = 8,
    parameter int unsigned SHIP_OFFSET = 15,
    parameter logic [23:0] COLOR       = 24'hFFFF00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 new_frame,
    input  logic                 fire,
    input  logic [9:0]           ship_x,
    input  logic [9:0]           ship_y,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic                 kill_valid,
    input  logic [3:0]           kill_idx,
    output logic [7:0]           R,
    output logic [7:0]           G,
    output logic [7:0]           B,
    output logic                 bullet_px,
    output logic [N_BULLETS-1:0] active,
    output logic                 fired,
    output logic                 busy
);

    localparam int unsigned IW = $clog2(N_BULLETS);
    localparam int unsigned CW = $clog2(COOLDOWN + 2);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_SPAWN  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [N_BULLETS-1:0] act_q, act_d;
    logic [9:0]           bx_q [N_BULLETS];
    logic [9:0]           bx_d [N_BULLETS];
    logic [9:0]           by_q [N_BULLETS];
    logic [9:0]           by_d [N_BULLETS];
    logic [CW-1:0]        cd_q, cd_d;
    logic                 pend_q, pend_d;
    logic                 nf_q;
    logic                 fired_q, fired_d;
    logic                 busy_q, busy_d;
    logic [23:0]          rgb_q, rgb_d;
    logic                 px_q, px_d;

    logic                 frame_tick;
    logic                 free_found;
    logic [IW-1:0]        free_idx;
    logic                 spawn_ok;
    logic [10:0]          spawn_sum;
    logic [9:0]           spawn_bx;
    logic                 hit;

    // Pixel hit test against every live slot, all compares widened to 11 bits
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < int'(N_BULLETS); k++) begin
            if (act_q[k]
                && ({1'b0, x} >= {1'b0, bx_q[k]})
                && ({1'b0, x} <  ({1'b0, bx_q[k]} + 11'(BULLET_W)))
                && ({1'b0, y} >= {1'b0, by_q[k]})
                && ({1'b0, y} <  ({1'b0, by_q[k]} + 11'(BULLET_H)))) begin
                hit = 1'b1;
            end
        end
        rgb_d = hit ? COLOR : 24'h0;
        px_d  = hit;
    end

    // Lowest free slot and the clamped spawn column
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = 0; k < int'(N_BULLETS); k++) begin
            if (!act_q[k] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(k);
            end
        end
        spawn_sum = 11'(ship_x) + 11'(SHIP_OFFSET);
        spawn_bx  = (spawn_sum > 11'(640 - BULLET_W)) ? 10'(640 - BULLET_W) : spawn_sum[9:0];
    end

    assign frame_tick = new_frame & ~nf_q;
    assign spawn_ok   = (state_q == ST_SPAWN) && pend_q && (cd_q == '0) && free_found
                        && (ship_y >= 10'(BULLET_H));

    // Next-state: frame pass FSM, slot updates, spawn, kill
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        act_d   = act_q;
        bx_d    = bx_q;
        by_d    = by_q;
        cd_d    = cd_q;
        pend_d  = pend_q | fire;
        fired_d = 1'b0;

        if (frame_tick && (cd_q != '0)) begin
            cd_d = cd_q - CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                end
            end
            ST_UPDATE: begin
                for (int k = 0; k < int'(N_BULLETS); k++) begin
                    if ((idx_q == IW'(k)) && act_q[k]
                        && !(kill_valid && (kill_idx == 4'(k)))) begin
                        if (by_q[k] < 10'(SPEED)) begin
                            act_d[k] = 1'b0;
                        end else begin
                            by_d[k] = by_q[k] - 10'(SPEED);
                        end
                    end
                end
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(N_BULLETS - 1)) begin
                    state_d = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                pend_d = 1'b0;
                if (spawn_ok) begin
                    for (int k = 0; k < int'(N_BULLETS); k++) begin
                        if (free_idx == IW'(k)) begin
                            act_d[k] = 1'b1;
                            bx_d[k]  = spawn_bx;
                            by_d[k]  = ship_y - 10'(BULLET_H);
                        end
                    end
                    fired_d = 1'b1;
                    cd_d    = CW'(COOLDOWN);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A freshly spawned slot was free, so the spawn takes precedence over a kill
        for (int k = 0; k < int'(N_BULLETS); k++) begin
            if (kill_valid && (kill_idx == 4'(k)) && !(spawn_ok && (free_idx == IW'(k)))) begin
                act_d[k] = 1'b0;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            act_q   <= '0;
            cd_q    <= '0;
            pend_q  <= 1'b0;
            nf_q    <= 1'b0;
            fired_q <= 1'b0;
            busy_q  <= 1'b0;
            rgb_q   <= '0;
            px_q    <= 1'b0;
            for (int k = 0; k < int'(N_BULLETS); k++) begin
                bx_q[k] <= '0;
                by_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            cd_q    <= cd_d;
            pend_q  <= pend_d;
            nf_q    <= new_frame;
            fired_q <= fired_d;
            busy_q  <= busy_d;
            rgb_q   <= rgb_d;
            px_q    <= px_d;
            for (int k = 0; k < int'(N_BULLETS); k++) begin
                bx_q[k] <= bx_d[k];
                by_q[k] <= by_d[k];
            end
        end
    end

    assign R         = rgb_q[23:16];
    assign G         = rgb_q[15:8];
    assign B         = rgb_q[7:0];
    assign bullet_px = px_q;
    assign active    = act_q;
    assign fired     = fired_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: directed scenarios plus randomized frames against a time-based
// behavioural model of the bullet pool.
module tb_bullet_pool;

    localparam int N  = 8;
    localparam int CD = 8;
    localparam logic [23:0] YEL = 24'hFFFF00;

    logic       clk = 1'b0;
    logic       rst, new_frame, fire, kill_valid;
    logic [9:0] ship_x, ship_y, x, y;
    logic [3:0] kill_idx;
    logic [7:0] R, G, B;
    logic       bullet_px, fired, busy;
    logic [N-1:0] active;

    always #5 clk = ~clk;

    bullet_pool #(
        .N_BULLETS(N), .BULLET_W(2), .BULLET_H(6), .SPEED(4), .COOLDOWN(CD),
        .SHIP_OFFSET(15), .COLOR(24'hFFFF00)
    ) dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .fire(fire),
        .ship_x(ship_x), .ship_y(ship_y), .x(x), .y(y),
        .kill_valid(kill_valid), .kill_idx(kill_idx),
        .R(R), .G(G), .B(B), .bullet_px(bullet_px),
        .active(active), .fired(fired), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;
    bit rnd_mode = 1'b0;
    int fired_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp_v, $time);
        end
    endtask

    // Behavioural model: slot arrays plus a count of cycles since the frame tick
    bit       m_act [N];
    int       m_bx  [N];
    int       m_by  [N];
    int       m_cd, phase;
    bit       m_pend, nf_q;
    bit [23:0] e_rgb;
    bit       e_px, e_fired, e_busy;
    bit [N-1:0] e_active;

    always @(posedge clk) begin : model
        bit tick, spawn, h;
        int tgt, s;
        if (rst) begin
            for (int k = 0; k < N; k++) begin m_act[k] = 0; m_bx[k] = 0; m_by[k] = 0; end
            m_cd = 0; m_pend = 0; phase = 0; nf_q = 0;
            e_rgb = 0; e_px = 0; e_fired = 0; e_busy = 0; e_active = 0;
        end else begin
            h = 0;
            for (int k = 0; k < N; k++)
                if (m_act[k] && int'(x) >= m_bx[k] && int'(x) < m_bx[k] + 2 &&
                    int'(y) >= m_by[k] && int'(y) < m_by[k] + 6) h = 1;
            tick  = new_frame && !nf_q;
            spawn = 0;
            tgt   = -1;
            if (phase >= 1 && phase <= N) begin
                s = phase - 1;
                if (m_act[s] && !(kill_valid && int'(kill_idx) == s)) begin
                    if (m_by[s] < 4) m_act[s] = 0;
                    else m_by[s] = m_by[s] - 4;
                end
            end
            if (phase == N + 1) begin
                for (int k = N - 1; k >= 0; k--) if (!m_act[k]) tgt = k;
                if (m_pend && m_cd == 0 && tgt >= 0 && int'(ship_y) >= 6) begin
                    spawn = 1;
                    m_bx[tgt]  = (int'(ship_x) + 15 > 638) ? 638 : int'(ship_x) + 15;
                    m_by[tgt]  = int'(ship_y) - 6;
                    m_act[tgt] = 1;
                end
            end
            if (kill_valid && int'(kill_idx) < N && !(spawn && int'(kill_idx) == tgt))
                m_act[kill_idx] = 0;
            if (phase == N + 1) m_pend = 0;
            else if (fire) m_pend = 1;
            if (spawn) m_cd = CD;
            else if (tick && m_cd > 0) m_cd = m_cd - 1;
            if (phase == 0 && tick) phase = 1;
            else if (phase == N + 1) phase = 0;
            else if (phase > 0) phase = phase + 1;
            e_rgb   = h ? YEL : 24'h0;
            e_px    = h;
            e_fired = spawn;
            e_busy  = (phase != 0);
            for (int k = 0; k < N; k++) e_active[k] = m_act[k];
            nf_q = new_frame;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (started) begin
            chk("rgb", {R, G, B}, e_rgb);
            chk("bullet_px", bullet_px, e_px);
            chk("active", active, e_active);
            chk("fired", fired, e_fired);
            chk("busy", busy, e_busy);
        end
        if (fired === 1'b1) fired_cnt++;
    end

    task automatic rand_inputs();
        int s;
        fire       = ($urandom_range(0, 5) == 0);
        kill_valid = ($urandom_range(0, 23) == 0);
        kill_idx   = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 31) == 0) begin
            ship_x = 10'($urandom_range(0, 1023));
            ship_y = 10'($urandom_range(0, 1023));
        end
        s = int'($urandom_range(0, N - 1));
        x = 10'(m_bx[s] + int'($urandom_range(0, 4)) - 2);
        y = 10'(m_by[s] + int'($urandom_range(0, 9)) - 2);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rnd_mode) rand_inputs();
        end
    endtask

    task automatic do_frame();
        new_frame = 1'b1;
        cyc(2);
        new_frame = 1'b0;
        cyc(20);
    endtask

    // Kill request lands on the UPDATE cycle of the given slot
    task automatic frame_kill(input logic [3:0] idx);
        new_frame = 1'b1;
        cyc(2);
        new_frame = 1'b0;
        cyc(int'(idx) - 1);
        kill_valid = 1'b1;
        kill_idx   = idx;
        cyc(1);
        kill_valid = 1'b0;
        cyc(20);
    endtask

    task automatic pix(input int xv, input int yv, input logic [23:0] ev, input string name);
        x = 10'(xv);
        y = 10'(yv);
        cyc(1);
        chk(name, {R, G, B}, ev);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int f0, second;
        rst = 1'b1; new_frame = 1'b0; fire = 1'b0; kill_valid = 1'b0; kill_idx = 4'd0;
        ship_x = 10'd0; ship_y = 10'd0; x = 10'd0; y = 10'd0;
        @(negedge clk);
        started = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("reset_rgb", {R, G, B}, 24'h0);
        chk("reset_active", active, 0);
        chk("reset_busy", busy, 0);

        // First spawn, render and movement
        ship_x = 10'd300; ship_y = 10'd400; fire = 1'b1;
        f0 = fired_cnt; do_frame();
        chk("first_spawn_count", fired_cnt - f0, 1);
        chk("first_spawn_active", active, 8'h01);
        pix(315, 394, YEL, "hit_top_left");
        pix(317, 394, 24'h0, "miss_right");
        pix(315, 400, 24'h0, "miss_below");
        pix(316, 399, YEL, "hit_bottom_right");
        f0 = fired_cnt; do_frame();
        chk("cooldown_no_spawn", fired_cnt - f0, 0);
        pix(315, 390, YEL, "moved_up");
        pix(315, 396, 24'h0, "old_row_clear");
        second = 0;
        for (int k = 3; k <= 12; k++) begin
            f0 = fired_cnt; do_frame();
            if (fired_cnt != f0 && second == 0) second = k;
        end
        chk("second_spawn_frame", second, 9);
        chk("two_active", active, 8'h03);

        // Fill the pool, then let the cooldown expire
        for (int k = 13; k <= 60; k++) do_frame();
        chk("pool_full", active, 8'hFF);
        fire = 1'b0;
        for (int k = 0; k < 6; k++) do_frame();
        fire = 1'b1; cyc(1); fire = 1'b0;
        f0 = fired_cnt; do_frame();
        chk("full_no_spawn", fired_cnt - f0, 0);
        kill_valid = 1'b1; kill_idx = 4'd7; cyc(1); kill_valid = 1'b0; cyc(1);
        chk("kill_idle", active, 8'h7F);
        f0 = fired_cnt; do_frame();
        chk("pend_cleared", fired_cnt - f0, 0);
        frame_kill(4'd2);
        chk("kill_during_update", active, 8'h7B);
        kill_valid = 1'b1; kill_idx = 4'd12; cyc(1); kill_valid = 1'b0; cyc(1);
        chk("kill_out_of_range", active, 8'h7B);

        // Right-edge clamp and removal near the top without wrap
        do_reset();
        ship_x = 10'd630; ship_y = 10'd13; fire = 1'b1; cyc(1); fire = 1'b0;
        f0 = fired_cnt; do_frame();
        chk("clamp_spawn", fired_cnt - f0, 1);
        pix(638, 7, YEL, "clamp_hit");
        pix(639, 12, YEL, "clamp_hit_corner");
        pix(637, 7, 24'h0, "clamp_left_miss");
        pix(638, 13, 24'h0, "clamp_below_miss");
        do_frame();
        pix(638, 3, YEL, "near_top");
        do_frame();
        chk("removed_at_top", active, 0);
        pix(638, 1023, 24'h0, "no_wrap");
        pix(638, 3, 24'h0, "gone");
        ship_y = 10'd4; fire = 1'b1;
        f0 = fired_cnt;
        for (int k = 0; k < 10; k++) do_frame();
        chk("low_ship_no_spawn", fired_cnt - f0, 0);
        fire = 1'b0;

        // Randomized frames
        do_reset();
        ship_x = 10'd200; ship_y = 10'd700;
        rnd_mode = 1'b1;
        for (int k = 0; k < 80; k++) do_frame();
        rnd_mode = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
